// File: rtl/audio_sample_streamer.sv
// Memory-mapped audio output FIFO: the CPU pushes samples over the bus and each rising
// edge of the asynchronous sample request pops one sample onto a parallel output.
module audio_sample_streamer #(
    parameter int DEPTH       = 16,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    input  logic                req_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_stb,
    output logic                irq_low
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(DEPTH / 4);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    logic [SAMPLE_W-1:0]    fifo_mem [DEPTH];

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_prev_q, req_prev_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   enable_q, enable_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;
    logic [SAMPLE_W-1:0]    sample_out_q, sample_out_d;
    logic                   sample_stb_q, sample_stb_d;
    logic [31:0]            rd_q, rd_d;

    reg_sel_e reg_sel;
    logic     req_edge, empty, full;
    logic     data_wr, ctrl_wr, flush, clear;
    logic     pop, push, underrun_set, overflow_set;
    logic     unused_bits;

    assign reg_sel  = reg_sel_e'(addr[3:2]);
    assign req_edge = sync_q[SYNC_STAGES-1] & ~req_prev_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);

    assign data_wr = we && (reg_sel == REG_DATA);
    assign ctrl_wr = we && (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr && wd[1];
    assign clear   = ctrl_wr && wd[2];

    // A pop frees a slot in the same cycle, so a write to a full FIFO is accepted alongside it.
    assign pop          = req_edge && enable_q && !empty && !flush;
    assign push         = data_wr && !flush && (!full || pop);
    assign underrun_set = req_edge && enable_q && empty;
    assign overflow_set = data_wr && full && !pop;

    assign unused_bits = ^{addr[31:4], addr[1:0], wd[31:SAMPLE_W]};

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        sync_d       = {sync_q[SYNC_STAGES-2:0], req_in};
        req_prev_d   = sync_q[SYNC_STAGES-1];
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        enable_d     = enable_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;
        sample_out_d = sample_out_q;
        sample_stb_d = 1'b0;
        rd_d         = '0;

        if (ctrl_wr) begin
            enable_d = wd[0];
        end

        // Clear first so a flag event in the same cycle overrides it.
        if (clear) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (underrun_set) begin
            underrun_d = 1'b1;
        end
        if (overflow_set) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            sample_out_d = fifo_mem[rd_ptr_q];
            sample_stb_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
            2'b01:   count_d = (count_q == '0) ? count_q : count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            sample_out_d = '0;
            sample_stb_d = 1'b0;
        end

        case (reg_sel)
            REG_STATUS: begin
                rd_d[0]    = empty;
                rd_d[1]    = full;
                rd_d[2]    = underrun_q;
                rd_d[3]    = overflow_q;
                rd_d[15:8] = 8'(count_q);
            end
            REG_CTRL: rd_d[0] = enable_q;
            default:  rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sync_q       <= '0;
            req_prev_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            enable_q     <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            sample_out_q <= '0;
            sample_stb_q <= 1'b0;
            rd_q         <= '0;
        end else begin
            sync_q       <= sync_d;
            req_prev_q   <= req_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            enable_q     <= enable_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
            sample_out_q <= sample_out_d;
            sample_stb_q <= sample_stb_d;
            rd_q         <= rd_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wd[SAMPLE_W-1:0];
        end
    end

    assign rd         = rd_q;
    assign sample_out = sample_out_q;
    assign sample_stb = sample_stb_q;
    assign irq_low    = enable_q && (count_q <= CNT_LOW);

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer: bus pushes, request pulses, flags, flush and reset.
module tb_audio_sample_streamer;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        req_in = 1'b0;
    logic [15:0] sample_out;
    logic        sample_stb;
    logic        irq_low;

    int checks = 0;
    int errors = 0;

    audio_sample_streamer #(.DEPTH(16), .SAMPLE_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .rd         (rd),
        .req_in     (req_in),
        .sample_out (sample_out),
        .sample_stb (sample_stb),
        .irq_low    (irq_low)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = {28'd0, a, 2'b00};
        wd   = d;
        @(negedge clk);
        we   = 1'b0;
        wd   = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        we   = 1'b0;
        addr = {28'd0, a, 2'b00};
        @(posedge clk);
        #1 d = rd;
    endtask

    // One req_in pulse; reports the cycle of the first strobe (0 = none) and the strobe count.
    task automatic req_pulse(output int stb_cycle, output int stb_cnt);
        stb_cycle = 0;
        stb_cnt   = 0;
        @(negedge clk);
        req_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (sample_stb) begin
                stb_cnt++;
                if (stb_cycle == 0) stb_cycle = k;
            end
            if (k == 4) req_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        int stb_seen = 0;
        logic [31:0] st;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_in = ~req_in;
            if (sample_stb) stb_seen++;
        end
        req_in = 1'b0;
        checks++;
        if (sample_out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sample_out: got %h expected 0000", sample_out);
        end
        checks++;
        if (stb_seen !== 0) begin
            errors++;
            $display("FAIL reset_stb: got %0d strobes expected 0", stb_seen);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd: got %h expected 00000000", rd);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_status: got %h expected 00000001", st);
        end
        checks++;
        if (irq_low !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq_low);
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_s [3] = '{16'h1111, 16'h2222, 16'h3333};
        int sc, sn;
        logic [31:0] st;
        for (int i = 0; i < 3; i++) bus_write(A_DATA, {16'd0, exp_s[i]});
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            req_pulse(sc, sn);
            checks++;
            if (sample_out !== exp_s[i]) begin
                errors++;
                $display("FAIL stream_sample[%0d]: got %h expected %h", i, sample_out, exp_s[i]);
            end
            checks++;
            if (sc !== 3 || sn !== 1) begin
                errors++;
                $display("FAIL stream_stb[%0d]: got cycle %0d count %0d expected cycle 3 count 1", i, sc, sn);
            end
        end
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0001) begin
            errors++;
            $display("FAIL stream_status: got %h expected 00000001", st);
        end
    endtask

    task automatic test_underrun();
        int sc, sn;
        logic [31:0] st;
        req_pulse(sc, sn);
        checks++;
        if (sample_out !== 16'h3333 || sn !== 0) begin
            errors++;
            $display("FAIL underrun_hold: got %h stb %0d expected 3333 stb 0", sample_out, sn);
        end
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0005) begin
            errors++;
            $display("FAIL underrun_status: got %h expected 00000005", st);
        end
        bus_write(A_CTRL, 32'h5);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0001) begin
            errors++;
            $display("FAIL underrun_clear: got %h expected 00000001", st);
        end
    endtask

    task automatic test_overflow();
        int sc, sn;
        int bad = 0;
        int dead_seen = 0;
        logic [31:0] st;
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h0000_A000 + i);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_1002) begin
            errors++;
            $display("FAIL full_status: got %h expected 00001002", st);
        end
        checks++;
        if (irq_low !== 1'b0) begin
            errors++;
            $display("FAIL full_irq: got %b expected 0", irq_low);
        end
        bus_write(A_DATA, 32'h0000_DEAD);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_100A) begin
            errors++;
            $display("FAIL overflow_status: got %h expected 0000100A", st);
        end
        for (int i = 0; i < 16; i++) begin
            req_pulse(sc, sn);
            if (sample_out !== 16'hA000 + 16'(i) || sn !== 1) bad++;
            if (sample_out === 16'hDEAD) dead_seen++;
        end
        checks++;
        if (bad !== 0 || dead_seen !== 0) begin
            errors++;
            $display("FAIL overflow_drain: got %0d bad pops %0d DEAD outputs expected 0 0", bad, dead_seen);
        end
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0009 || irq_low !== 1'b1) begin
            errors++;
            $display("FAIL overflow_after: got %h irq %b expected 00000009 irq 1", st, irq_low);
        end
        bus_write(A_CTRL, 32'h5);
    endtask

    task automatic test_push_pop_full();
        int sc, sn;
        int bad = 0;
        logic [31:0] st;
        for (int i = 0; i < 16; i++) bus_write(A_DATA, 32'h0000_B000 + i);
        @(negedge clk);
        req_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        we   = 1'b1;
        addr = {28'd0, A_DATA, 2'b00};
        wd   = 32'h0000_C0DE;
        @(posedge clk);
        #1;
        checks++;
        if (sample_stb !== 1'b1 || sample_out !== 16'hB000) begin
            errors++;
            $display("FAIL pushpop_pop: got stb %b sample %h expected 1 B000", sample_stb, sample_out);
        end
        @(negedge clk);
        we     = 1'b0;
        req_in = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_1002) begin
            errors++;
            $display("FAIL pushpop_status: got %h expected 00001002", st);
        end
        for (int i = 1; i < 16; i++) begin
            req_pulse(sc, sn);
            if (sample_out !== 16'hB000 + 16'(i)) bad++;
        end
        req_pulse(sc, sn);
        checks++;
        if (bad !== 0 || sample_out !== 16'hC0DE) begin
            errors++;
            $display("FAIL pushpop_drain: got %0d bad last %h expected 0 C0DE", bad, sample_out);
        end
    endtask

    task automatic test_push_pop_empty();
        logic [31:0] st;
        @(negedge clk);
        req_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        we   = 1'b1;
        addr = {28'd0, A_DATA, 2'b00};
        wd   = 32'h0000_1234;
        @(posedge clk);
        #1;
        checks++;
        if (sample_stb !== 1'b0 || sample_out !== 16'hC0DE) begin
            errors++;
            $display("FAIL emptypp_nopop: got stb %b sample %h expected 0 C0DE", sample_stb, sample_out);
        end
        @(negedge clk);
        we     = 1'b0;
        req_in = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0104) begin
            errors++;
            $display("FAIL emptypp_status: got %h expected 00000104", st);
        end
        bus_write(A_CTRL, 32'h5);
    endtask

    task automatic test_flush();
        logic [31:0] st;
        for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h0000_5000 + i);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0500 || irq_low !== 1'b0) begin
            errors++;
            $display("FAIL flush_before: got %h irq %b expected 00000500 irq 0", st, irq_low);
        end
        bus_write(A_CTRL, 32'h3);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0001 || sample_out !== 16'h0000 || irq_low !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: got %h sample %h irq %b expected 00000001 0000 1", st, sample_out, irq_low);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] st;
        bus_write(A_DATA, 32'h0000_7777);
        bus_write(A_DATA, 32'h0000_8888);
        @(negedge clk);
        addr   = {28'd0, A_STATUS, 2'b00};
        req_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample_stb !== 1'b1 || sample_out !== 16'h7777 || rd === 32'h0) begin
            errors++;
            $display("FAIL midreset_pre: got stb %b sample %h rd %h expected 1 7777 nonzero", sample_stb, sample_out, rd);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (sample_out !== 16'h0 || sample_stb !== 1'b0 || rd !== 32'h0 || irq_low !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got sample %h stb %b rd %h irq %b expected all 0", sample_out, sample_stb, rd, irq_low);
        end
        req_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(A_STATUS, st);
        checks++;
        if (st !== 32'h0000_0001) begin
            errors++;
            $display("FAIL midreset_status: got %h expected 00000001", st);
        end
    endtask

    task automatic test_disabled();
        int sc, sn;
        logic [31:0] st;
        bus_write(A_DATA, 32'h0000_9999);
        req_pulse(sc, sn);
        bus_read(A_STATUS, st);
        checks++;
        if (sn !== 0 || sample_out !== 16'h0 || st !== 32'h0000_0100) begin
            errors++;
            $display("FAIL disabled_ignore: got stb %0d sample %h status %h expected 0 0000 00000100", sn, sample_out, st);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_overflow();
        test_push_pop_full();
        test_push_pop_empty();
        test_flush();
        test_reset_mid();
        test_disabled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
